// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector in order,
// samples the DUT after a settling dwell and tallies mismatches.
module truth_table_sweeper #(
   parameter int                N            = 4,
   parameter int                DWELL        = 2,
   parameter logic [2**N-1:0]   EXPECTED     = 16'h0000,
   parameter bit                STOP_ON_FAIL = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         dut_out,
   output logic [N-1:0] dut_in,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   err_count,
   output logic [N-1:0] first_fail_vec,
   output logic         first_fail_valid
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [N-1:0]  VEC_ONE  = N'(1);
   localparam logic [N:0]    ERR_ONE  = (N + 1)'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [N-1:0]  vec;
   logic [CW-1:0] dwell_cnt;
   logic          clear;
   logic          sample;
   logic          mismatch;
   logic          last_vec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      sample    = 1'b0;
      mismatch  = 1'b0;
      last_vec  = (vec == {N{1'b1}});
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = RUN;
               clear     = 1'b1;
            end
         end
         RUN: begin
            if (dwell_cnt == LAST_CNT) begin
               sample   = 1'b1;
               mismatch = (dut_out != EXPECTED[vec]);
               if (last_vec || (STOP_ON_FAIL && mismatch))
                  state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Results survive into DONE; only a new start or reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec              <= '0;
         dwell_cnt        <= '0;
         err_count        <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else if (clear) begin
         vec              <= '0;
         dwell_cnt        <= '0;
         err_count        <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else if (state == RUN) begin
         if (sample) begin
            dwell_cnt <= '0;
            if (mismatch) begin
               err_count <= err_count + ERR_ONE;
               if (!first_fail_valid) begin
                  first_fail_vec   <= vec;
                  first_fail_valid <= 1'b1;
               end
            end
            if (state_nxt == RUN)
               vec <= vec + VEC_ONE;
         end else begin
            dwell_cnt <= dwell_cnt + CNT_ONE;
         end
      end
   end

   assign dut_in = vec;
   assign busy   = (state == RUN);
   assign done   = (state == DONE);
   assign pass   = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: clean, faulty, stop-on-fail,
// restart, async reset and N=1 boundary sweeps.
module tb_truth_table_sweeper;

   logic clk;
   logic rst_n;

   logic        start_a, dut_out_a, busy_a, done_a, pass_a, ffvalid_a;
   logic [3:0]  dut_in_a, ffv_a;
   logic [4:0]  err_a;
   logic [15:0] exp_a;
   logic [15:0] fault_a;

   logic        start_b, dut_out_b, busy_b, done_b, pass_b, ffvalid_b;
   logic [3:0]  dut_in_b, ffv_b;
   logic [4:0]  err_b;
   logic [15:0] fault_b;

   logic        start_c, dut_out_c, busy_c, done_c, pass_c, ffvalid_c;
   logic [0:0]  dut_in_c, ffv_c;
   logic [1:0]  err_c;
   logic [1:0]  exp_c;

   int n_checks;
   int n_fails;

   truth_table_sweeper #(
      .N(4), .DWELL(2), .EXPECTED(16'hA5C3), .STOP_ON_FAIL(1'b0)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a),
      .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .first_fail_vec(ffv_a),
      .first_fail_valid(ffvalid_a)
   );

   truth_table_sweeper #(
      .N(4), .DWELL(2), .EXPECTED(16'hA5C3), .STOP_ON_FAIL(1'b1)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b),
      .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .first_fail_vec(ffv_b),
      .first_fail_valid(ffvalid_b)
   );

   truth_table_sweeper #(
      .N(1), .DWELL(1), .EXPECTED(2'b10), .STOP_ON_FAIL(1'b0)
   ) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .dut_out(dut_out_c),
      .dut_in(dut_in_c), .busy(busy_c), .done(done_c), .pass(pass_c),
      .err_count(err_c), .first_fail_vec(ffv_c),
      .first_fail_valid(ffvalid_c)
   );

   // Behavioural DUTs: the reference table with optional inverted entries.
   assign dut_out_a = exp_a[dut_in_a] ^ fault_a[dut_in_a];
   assign dut_out_b = exp_a[dut_in_b] ^ fault_b[dut_in_b];
   assign dut_out_c = exp_c[dut_in_c];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Start is raised after a falling edge, caught by the next rising edge,
   // and the task returns on the falling edge right after that edge.
   task automatic pulse_a();
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({busy_a, done_a, pass_a, ffvalid_a} !== 4'b0000) begin
         n_fails++;
         $display("FAIL reset_flags got=%b want=0000",
                  {busy_a, done_a, pass_a, ffvalid_a});
      end
      n_checks++;
      if ({dut_in_a, err_a, ffv_a} !== 13'd0) begin
         n_fails++;
         $display("FAIL reset_data dut_in=%0d err=%0d ffv=%0d want 0",
                  dut_in_a, err_a, ffv_a);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy_a, done_a, dut_in_a} !== 6'd0) begin
         n_fails++;
         $display("FAIL idle_after_reset busy=%b done=%b dut_in=%0d",
                  busy_a, done_a, dut_in_a);
      end
   endtask

   task automatic test_clean_sweep();
      fault_a = 16'h0000;
      pulse_a();
      for (int c = 0; c < 32; c++) begin
         n_checks++;
         if (dut_in_a !== 4'(c / 2) || busy_a !== 1'b1 || done_a !== 1'b0) begin
            n_fails++;
            $display("FAIL clean_step c=%0d dut_in=%0d busy=%b done=%b want %0d 1 0",
                     c, dut_in_a, busy_a, done_a, c / 2);
         end
         @(negedge clk);
      end
      n_checks++;
      if ({done_a, busy_a, pass_a, ffvalid_a, err_a} !== {4'b1010, 5'd0}) begin
         n_fails++;
         $display("FAIL clean_done done=%b busy=%b pass=%b ffvalid=%b err=%0d",
                  done_a, busy_a, pass_a, ffvalid_a, err_a);
      end
      n_checks++;
      if (dut_in_a !== 4'd15) begin
         n_fails++;
         $display("FAIL clean_hold dut_in=%0d want 15", dut_in_a);
      end
   endtask

   task automatic test_single_fault();
      fault_a = 16'h0020;
      pulse_a();
      repeat (31) @(negedge clk);
      n_checks++;
      if (done_a !== 1'b0) begin
         n_fails++;
         $display("FAIL fault_early_done done=%b want 0", done_a);
      end
      @(negedge clk);
      n_checks++;
      if (done_a !== 1'b1 || pass_a !== 1'b0) begin
         n_fails++;
         $display("FAIL fault_done done=%b pass=%b want 1 0", done_a, pass_a);
      end
      n_checks++;
      if (err_a !== 5'd1 || ffv_a !== 4'd5 || ffvalid_a !== 1'b1) begin
         n_fails++;
         $display("FAIL fault_result err=%0d ffv=%0d ffvalid=%b want 1 5 1",
                  err_a, ffv_a, ffvalid_a);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (err_a !== 5'd1 || done_a !== 1'b1 || dut_in_a !== 4'd15) begin
         n_fails++;
         $display("FAIL fault_held err=%0d done=%b dut_in=%0d",
                  err_a, done_a, dut_in_a);
      end
   endtask

   task automatic test_restart_and_mid_start();
      fault_a = 16'h0000;
      pulse_a();
      n_checks++;
      if (err_a !== 5'd0 || ffvalid_a !== 1'b0 || done_a !== 1'b0) begin
         n_fails++;
         $display("FAIL restart_clear err=%0d ffvalid=%b done=%b want 0 0 0",
                  err_a, ffvalid_a, done_a);
      end
      for (int c = 0; c < 32; c++) begin
         if (c == 10) start_a = 1'b1;
         if (c == 11) start_a = 1'b0;
         n_checks++;
         if (dut_in_a !== 4'(c / 2) || busy_a !== 1'b1) begin
            n_fails++;
            $display("FAIL midstart_step c=%0d dut_in=%0d busy=%b want %0d 1",
                     c, dut_in_a, busy_a, c / 2);
         end
         @(negedge clk);
      end
      n_checks++;
      if (done_a !== 1'b1 || pass_a !== 1'b1 || err_a !== 5'd0) begin
         n_fails++;
         $display("FAIL midstart_done done=%b pass=%b err=%0d want 1 1 0",
                  done_a, pass_a, err_a);
      end
   endtask

   task automatic test_stop_on_fail();
      fault_b = 16'h0208;
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (int c = 0; c < 8; c++) begin
         n_checks++;
         if (done_b !== 1'b0 || dut_in_b !== 4'(c / 2)) begin
            n_fails++;
            $display("FAIL stop_step c=%0d done=%b dut_in=%0d want 0 %0d",
                     c, done_b, dut_in_b, c / 2);
         end
         @(negedge clk);
      end
      n_checks++;
      if (done_b !== 1'b1 || busy_b !== 1'b0 || pass_b !== 1'b0) begin
         n_fails++;
         $display("FAIL stop_done done=%b busy=%b pass=%b want 1 0 0",
                  done_b, busy_b, pass_b);
      end
      n_checks++;
      if (err_b !== 5'd1 || ffv_b !== 4'd3 || ffvalid_b !== 1'b1) begin
         n_fails++;
         $display("FAIL stop_result err=%0d ffv=%0d ffvalid=%b want 1 3 1",
                  err_b, ffv_b, ffvalid_b);
      end
      @(negedge clk);
      n_checks++;
      if (dut_in_b !== 4'd3 || done_b !== 1'b1) begin
         n_fails++;
         $display("FAIL stop_hold dut_in=%0d done=%b want 3 1", dut_in_b, done_b);
      end
   endtask

   task automatic test_n1_boundary();
      @(negedge clk); start_c = 1'b1;
      @(negedge clk); start_c = 1'b0;
      n_checks++;
      if (dut_in_c !== 1'b0 || busy_c !== 1'b1) begin
         n_fails++;
         $display("FAIL n1_vec0 dut_in=%b busy=%b want 0 1", dut_in_c, busy_c);
      end
      @(negedge clk);
      n_checks++;
      if (dut_in_c !== 1'b1 || done_c !== 1'b0) begin
         n_fails++;
         $display("FAIL n1_vec1 dut_in=%b done=%b want 1 0", dut_in_c, done_c);
      end
      @(negedge clk);
      n_checks++;
      if (done_c !== 1'b1 || pass_c !== 1'b1 || err_c !== 2'd0) begin
         n_fails++;
         $display("FAIL n1_done done=%b pass=%b err=%0d want 1 1 0",
                  done_c, pass_c, err_c);
      end
   endtask

   task automatic test_all_fail();
      fault_a = 16'hFFFF;
      pulse_a();
      repeat (32) @(negedge clk);
      n_checks++;
      if (err_a !== 5'b10000 || ffv_a !== 4'd0 || ffvalid_a !== 1'b1) begin
         n_fails++;
         $display("FAIL allfail_result err=%0d ffv=%0d ffvalid=%b want 16 0 1",
                  err_a, ffv_a, ffvalid_a);
      end
      n_checks++;
      if (done_a !== 1'b1 || pass_a !== 1'b0) begin
         n_fails++;
         $display("FAIL allfail_done done=%b pass=%b want 1 0", done_a, pass_a);
      end
   endtask

   task automatic test_async_reset();
      pulse_a();
      repeat (14) @(negedge clk);
      n_checks++;
      if (dut_in_a !== 4'd7 || err_a !== 5'd7) begin
         n_fails++;
         $display("FAIL areset_setup dut_in=%0d err=%0d want 7 7", dut_in_a, err_a);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy_a, done_a, pass_a, ffvalid_a} !== 4'b0000) begin
         n_fails++;
         $display("FAIL areset_flags got=%b want 0000",
                  {busy_a, done_a, pass_a, ffvalid_a});
      end
      n_checks++;
      if ({dut_in_a, err_a, ffv_a} !== 13'd0) begin
         n_fails++;
         $display("FAIL areset_data dut_in=%0d err=%0d ffv=%0d want 0",
                  dut_in_a, err_a, ffv_a);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (busy_a !== 1'b0 || dut_in_a !== 4'd0 || err_a !== 5'd0) begin
         n_fails++;
         $display("FAIL areset_idle busy=%b dut_in=%0d err=%0d want 0 0 0",
                  busy_a, dut_in_a, err_a);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst_n    = 1'b0;
      start_a  = 1'b0;
      start_b  = 1'b0;
      start_c  = 1'b0;
      exp_a    = 16'hA5C3;
      exp_c    = 2'b10;
      fault_a  = 16'h0000;
      fault_b  = 16'h0000;
      repeat (2) @(negedge clk);
      test_reset();
      test_clean_sweep();
      test_single_fault();
      test_restart_and_mid_start();
      test_stop_on_fail();
      test_n1_boundary();
      test_all_fail();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Self-checking exhaustive stimulus engine for an N-input, 1-output combinational block. On start it drives every input vector 0..2^N-1 in ascending order, holds each for DWELL cycles, samples the DUT output, and compares it against a parametrised expected truth table. Accumulated error count, first-failing vector and pass/done flags replace manual waveform inspection in lab benches.

Parameters:
N, 4, DUT input width (1..8)
DWELL, 2, clock cycles each vector is held (>=1)
EXPECTED, 16'h0000, 2^N-bit truth table; bit v = expected DUT output for vector v
STOP_ON_FAIL, 0, 1 = end sweep at first mismatch; 0 = sweep all vectors

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; sampled in IDLE or DONE only
dut_out  in  1  DUT response to dut_in
dut_in  out  N  current stimulus vector; dut_in[N-1] = MSB
busy  out  1  high while sweep in progress
done  out  1  high from sweep end until next start
pass  out  1  done && err_count==0
err_count  out  N+1  number of mismatching vectors
first_fail_vec  out  N  first vector that mismatched
first_fail_valid  out  1  first_fail_vec holds a valid value

Behaviour:
- Reset (rst_n low, async, any state): state=IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, dwell counter=0. Takes effect immediately, including mid-sweep.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge -> RUN; vec=0, dwell_cnt=0, err_count=0, first_fail_valid=0, first_fail_vec=0, done=0.
- RUN: busy=1; dut_in=vec. dwell_cnt increments each edge. At the edge where dwell_cnt==DWELL-1 (sample edge), compare dut_out to EXPECTED[vec]:
  - mismatch: err_count+1; if first_fail_valid==0, first_fail_vec=vec, first_fail_valid=1.
  - then if vec==2^N-1, or (STOP_ON_FAIL==1 and mismatch) -> DONE; else vec+1, dwell_cnt=0.
- dut_out is sampled only at the sample edge; the first DWELL-1 cycles of each vector give the DUT settling time.
- Latency: start sampled at edge k -> done=1 after edge k+2^N*DWELL (full sweep). With STOP_ON_FAIL and first failure at vector f -> done after edge k+(f+1)*DWELL.
- DONE: busy=0, done=1, pass=(err_count==0). dut_in holds the last vector applied. All results are held stable. start=1 -> same transition as from IDLE (results cleared, restart at vec 0).
- start while RUN: ignored, no restart.
- vec never wraps. Sweep ends at 2^N-1. err_count width N+1 holds max 2^N without saturation.
- start and rst_n low together: reset wins.

Test Plan:
- N=4, DWELL=2, EXPECTED=16'hA5C3, DUT model = exact table; pulse start -> dut_in steps 0..15, each for 2 cycles; done rises 32 cycles after start edge; err_count=0, pass=1, first_fail_valid=0.
- Same, DUT output inverted at vector 5 only -> err_count=1, first_fail_vec=5, first_fail_valid=1, pass=0; done still at 32 cycles.
- STOP_ON_FAIL=1, faults at vectors 3 and 9 -> done after 8 cycles; err_count=1, first_fail_vec=3, dut_in holds 4'd3.
- Assert rst_n low asynchronously (between edges) while dut_in=7 -> all outputs 0 immediately; state IDLE; no activity until next start.
- Pulse start again mid-RUN -> ignored, sweep completes normally. Pulse start in DONE after a failing run -> err_count and first_fail_valid cleared, new sweep from 0 passes with a correct DUT.
- Boundary: N=1, DWELL=1, EXPECTED=2'b10, correct DUT -> done 2 cycles after start, pass=1. All-fail DUT with N=4 -> err_count=16 (5'b10000), first_fail_vec=0.
